// File: rtl/ex_muldiv_pkg.sv
// Shared types and operand-sign helpers for the iterative RV32M multiply/divide unit.
package ex_muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    function automatic logic rs1_is_signed(input md_op_e op);
        return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic rs2_is_signed(input md_op_e op);
        return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/md_div_core.sv
// Restoring-divide step datapath: one quotient bit per enabled cycle on unsigned magnitudes.
module md_div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_nxt,
    output logic [XLEN-1:0] quo_nxt
);

    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] dsr;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    // rem < divisor always holds, so the shifted value fits in XLEN+1 bits and
    // the top bit of the difference is a clean borrow flag.
    always_comb begin
        shifted = {rem, quo[XLEN-1]};
        diff    = shifted - {1'b0, dsr};
        if (!diff[XLEN]) begin
            rem_nxt = diff[XLEN-1:0];
            quo_nxt = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_nxt = shifted[XLEN-1:0];
            quo_nxt = {quo[XLEN-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem <= '0;
            quo <= '0;
            dsr <= '0;
        end else if (load) begin
            rem <= '0;
            quo <= dividend;
            dsr <= divisor;
        end else if (step) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative RV32M unit: shift-add multiply and restoring divide, one bit per cycle,
// stalling the front of the pipe while it iterates.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int REGADDR = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_flag,
    input  logic               md_start,
    input  logic [2:0]         md_op,
    input  logic [XLEN-1:0]    md_rs1_data,
    input  logic [XLEN-1:0]    md_rs2_data,
    input  logic [REGADDR-1:0] md_rd_addr,
    output logic               md_stall_req,
    output logic               md_done,
    output logic [XLEN-1:0]    md_result,
    output logic [REGADDR-1:0] md_rd_addr_o,
    output logic               md_rd_enable
);

    localparam int            CW   = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e          state;
    logic [CW-1:0]      count;
    md_op_e             op;
    logic [REGADDR-1:0] rd;
    logic               neg_a;
    logic               neg_b;
    logic [XLEN-1:0]    mcand;
    logic [2*XLEN-1:0]  acc;
    logic               done_r;
    logic [XLEN-1:0]    result_r;

    md_op_e          op_in;
    logic            sa_in;
    logic            sb_in;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_zero;
    logic            div_ovf;
    logic            fast_hit;
    logic [XLEN-1:0] fast_res;

    // Magnitudes of 0x80000000 come out as unsigned 2^31, which is exactly what we want.
    always_comb begin
        op_in    = md_op_e'(md_op);
        sa_in    = rs1_is_signed(op_in) && md_rs1_data[XLEN-1];
        sb_in    = rs2_is_signed(op_in) && md_rs2_data[XLEN-1];
        mag_a    = sa_in ? -md_rs1_data : md_rs1_data;
        mag_b    = sb_in ? -md_rs2_data : md_rs2_data;
        div_zero = op_in[2] && (md_rs2_data == '0);
        div_ovf  = (op_in == MD_DIV || op_in == MD_REM) &&
                   (md_rs1_data == SMIN) && (md_rs2_data == '1);
        fast_hit = div_zero || div_ovf;
        if (div_zero) fast_res = op_in[1] ? md_rs1_data : '1;
        else          fast_res = op_in[1] ? '0 : SMIN;
    end

    logic [XLEN:0]     hi_sum;
    logic [2*XLEN-1:0] acc_nxt;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   rem_nxt;
    logic [XLEN-1:0]   quo_nxt;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   final_res;

    // The low half of acc starts as the multiplier and is shifted out as the product shifts in.
    always_comb begin
        hi_sum = {1'b0, acc[2*XLEN-1:XLEN]};
        if (acc[0]) hi_sum = hi_sum + {1'b0, mcand};
        acc_nxt = {hi_sum, acc[XLEN-1:1]};

        prod    = (neg_a ^ neg_b) ? -acc_nxt : acc_nxt;
        quo_fix = (neg_a ^ neg_b) ? -quo_nxt : quo_nxt;
        rem_fix = neg_a ? -rem_nxt : rem_nxt;

        if (op[2])              final_res = op[1] ? rem_fix : quo_fix;
        else if (op == MD_MUL)  final_res = prod[XLEN-1:0];
        else                    final_res = prod[2*XLEN-1:XLEN];
    end

    md_div_core #(.XLEN(XLEN)) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (state == MD_IDLE && md_start && !ex_flag),
        .step     (state == MD_CALC && op[2] && !ex_flag),
        .dividend (mag_a),
        .divisor  (mag_b),
        .rem_nxt  (rem_nxt),
        .quo_nxt  (quo_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= MD_IDLE;
            count    <= '0;
            op       <= MD_MUL;
            rd       <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            mcand    <= '0;
            acc      <= '0;
            done_r   <= 1'b0;
            result_r <= '0;
        end else if (ex_flag) begin
            state  <= MD_IDLE;
            count  <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (md_start) begin
                        op    <= op_in;
                        rd    <= md_rd_addr;
                        neg_a <= sa_in;
                        neg_b <= sb_in;
                        mcand <= mag_a;
                        acc   <= {{XLEN{1'b0}}, mag_b};
                        count <= '0;
                        if (fast_hit) begin
                            state    <= MD_DONE;
                            done_r   <= 1'b1;
                            result_r <= fast_res;
                        end else begin
                            state <= MD_CALC;
                        end
                    end
                end
                MD_CALC: begin
                    count <= count + 1'b1;
                    if (!op[2]) acc <= acc_nxt;
                    if (count == LAST) begin
                        state    <= MD_DONE;
                        done_r   <= 1'b1;
                        result_r <= final_res;
                    end
                end
                // md_start here is the same instruction still sitting in EX.
                MD_DONE: state <= MD_IDLE;
                default: state <= MD_IDLE;
            endcase
        end
    end

    assign md_stall_req = !ex_flag && ((state == MD_IDLE && md_start) || state == MD_CALC);
    assign md_done      = done_r && !ex_flag;
    assign md_result    = result_r;
    assign md_rd_addr_o = rd;
    assign md_rd_enable = md_done && (rd != '0);

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed RV32M corner cases plus randomized ops vs. an arithmetic model.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_flag = 1'b0;
    logic        md_start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] md_rs1_data = '0;
    logic [31:0] md_rs2_data = '0;
    logic [4:0]  md_rd_addr = '0;
    logic        md_stall_req;
    logic        md_done;
    logic [31:0] md_result;
    logic [4:0]  md_rd_addr_o;
    logic        md_rd_enable;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_muldiv #(.XLEN(32), .REGADDR(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_flag      (ex_flag),
        .md_start     (md_start),
        .md_op        (md_op),
        .md_rs1_data  (md_rs1_data),
        .md_rs2_data  (md_rs2_data),
        .md_rd_addr   (md_rd_addr),
        .md_stall_req (md_stall_req),
        .md_done      (md_done),
        .md_result    (md_result),
        .md_rd_addr_o (md_rd_addr_o),
        .md_rd_enable (md_rd_enable)
    );

    // RISC-V M semantics straight from the ISA rules, using 64-bit host arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Called at posedge+1 (cycle 0); returns at posedge+1 of the cycle after md_done.
    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        logic [31:0] exp_res;
        int          exp_lat;
        int          stall_miss;
        bit          seen;
        exp_res    = ref_md(op, a, b);
        exp_lat    = ref_latency(op, a, b);
        stall_miss = 0;
        seen       = 0;
        md_op = op; md_rs1_data = a; md_rs2_data = b; md_rd_addr = rd; md_start = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            if (md_done) begin
                seen = 1;
                total++;
                if (cyc != exp_lat) begin
                    bad++; $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
                end
                total++;
                if (md_result !== exp_res) begin
                    bad++; $display("FAIL %s result: got %h want %h (op=%0d a=%h b=%h)", name, md_result, exp_res, op, a, b);
                end
                total++;
                if (md_rd_addr_o !== rd || md_rd_enable !== (rd != 0)) begin
                    bad++; $display("FAIL %s rd: got addr=%0d en=%b want addr=%0d en=%b", name, md_rd_addr_o, md_rd_enable, rd, rd != 0);
                end
                total++;
                if (md_stall_req !== 1'b0) begin
                    bad++; $display("FAIL %s stall_in_done: got %b want 0", name, md_stall_req);
                end
                break;
            end
            if (md_stall_req !== 1'b1) stall_miss++;
            @(posedge clk); #1;
        end
        total++;
        if (!seen) begin
            bad++; $display("FAIL %s timeout: no md_done within 100 cycles", name);
        end
        total++;
        if (stall_miss != 0) begin
            bad++; $display("FAIL %s stall_before_done: %0d cycles low, want 0", name, stall_miss);
        end
        @(posedge clk); #1;
        md_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; md_start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({md_done, md_result, md_rd_addr_o, md_rd_enable, md_stall_req} !== '0) begin
            bad++; $display("FAIL reset_outputs: got done=%b res=%h rd=%0d en=%b stall=%b want all 0",
                            md_done, md_result, md_rd_addr_o, md_rd_enable, md_stall_req);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        do_op("mul_7x_m3",    3'd0, 32'd7,         32'hFFFF_FFFD, 5'd3);
        do_op("mulhu_ff",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
        do_op("mulh_ff",      3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
        do_op("mulhsu_ff",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
        do_op("mulh_min_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd7);
    endtask

    task automatic test_div();
        do_op("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
        do_op("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
        do_op("divu_by0",   3'd5, 32'd100,       32'd0,         5'd10);
        do_op("rem_m7_by0", 3'd6, 32'hFFFF_FFF9, 32'd0,         5'd11);
        do_op("div_m7_2",   3'd4, 32'hFFFF_FFF9, 32'd2,         5'd12);
        do_op("rem_m7_2",   3'd6, 32'hFFFF_FFF9, 32'd2,         5'd13);
        do_op("divu_big",   3'd5, 32'hFFFF_FFFF, 32'd1,         5'd14);
        do_op("div_min_2",  3'd4, 32'h8000_0000, 32'd2,         5'd15);
    endtask

    task automatic test_flush();
        bit spurious;
        md_op = 3'd0; md_rs1_data = 32'd1234; md_rs2_data = 32'd5678; md_rd_addr = 5'd20; md_start = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        ex_flag = 1'b1;
        @(negedge clk);
        total++;
        if (md_stall_req !== 1'b0 || md_done !== 1'b0) begin
            bad++; $display("FAIL flush_cycle: got stall=%b done=%b want 0 0", md_stall_req, md_done);
        end
        @(posedge clk); #1;
        ex_flag = 1'b0; md_start = 1'b0;
        spurious = 0;
        repeat (40) begin
            @(negedge clk);
            if (md_done || md_stall_req) spurious = 1;
        end
        total++;
        if (spurious) begin
            bad++; $display("FAIL flush_killed: got late done/stall after flush want none");
        end
        @(posedge clk); #1;
        do_op("mul_after_flush", 3'd0, 32'd3, 32'd4, 5'd21);

        // Flush landing on the DONE cycle of a fast-path op must suppress md_done.
        md_op = 3'd5; md_rs1_data = 32'd9; md_rs2_data = 32'd0; md_rd_addr = 5'd22; md_start = 1'b1;
        @(posedge clk); #1;
        ex_flag = 1'b1;
        @(negedge clk);
        total++;
        if (md_done !== 1'b0 || md_rd_enable !== 1'b0 || md_stall_req !== 1'b0) begin
            bad++; $display("FAIL flush_in_done: got done=%b en=%b stall=%b want 0 0 0", md_done, md_rd_enable, md_stall_req);
        end
        @(posedge clk); #1;
        ex_flag = 1'b0; md_start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        md_op = 3'd0; md_rs1_data = 32'hDEAD_BEEF; md_rs2_data = 32'h1234_5678; md_rd_addr = 5'd17; md_start = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({md_done, md_result, md_rd_addr_o, md_rd_enable} !== '0) begin
            bad++; $display("FAIL reset_mid: got done=%b res=%h rd=%0d en=%b want all 0",
                            md_done, md_result, md_rd_addr_o, md_rd_enable);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        do_op("fresh_after_rst", 3'd0, 32'd6, 32'd7, 5'd0);
    endtask

    task automatic test_random();
        logic [31:0] specials [5];
        logic [31:0] a, b;
        logic [2:0]  op;
        specials[0] = 32'h0; specials[1] = 32'h1; specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h8000_0000; specials[4] = 32'h7FFF_FFFF;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(0, 31);
            do_op($sformatf("rand%0d", i), op, a, b, 5'($urandom_range(0, 31)));
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_flush();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
